// File: rtl/pattern_scan_gen.sv
// Scan-bar test pattern for the 2-half RGB LED matrix: a BAR_W-thick bar bounces or wraps along rows or columns.
// Build option PATTERN_SCAN_MIRROR_EN adds a second bar mirrored about the axis centre.
module pattern_scan_gen #(
    parameter int EFFECT_TIMER = 100_000,
    parameter int BAR_W        = 1,
    localparam int GL_NUM_ROW_PIXELS = 32,
    localparam int GL_NUM_COL_PIXELS = 64
) (
    input  logic                           clk_in,
    input  logic                           n_reset_in,
    input  logic                           enable_in,
    input  logic [2:0]                     colour_in,
    input  logic [1:0]                     mode_in,
    output logic [6*GL_NUM_COL_PIXELS-1:0] row_out,
    output logic [3:0]                     row_address_out,
    output logic                           sweep_done_out
);
    // row_out packing, MSB first: bot_b, bot_g, bot_r, top_b, top_g, top_r; bit c of a field = column c
    localparam int N  = GL_NUM_COL_PIXELS;
    localparam int PW = $clog2(GL_NUM_COL_PIXELS) + 1;
    localparam int TW = $clog2(EFFECT_TIMER + 1);
    localparam logic [PW-1:0] POS_MAX_V = PW'(GL_NUM_ROW_PIXELS - BAR_W);
    localparam logic [PW-1:0] POS_MAX_H = PW'(GL_NUM_COL_PIXELS - BAR_W);
    localparam logic [PW-1:0] HALF      = PW'(GL_NUM_ROW_PIXELS / 2);

    if (BAR_W < 1 || BAR_W >= GL_NUM_ROW_PIXELS) begin : g_bad_bar_w
        $error("pattern_scan_gen: BAR_W must satisfy 1 <= BAR_W < GL_NUM_ROW_PIXELS");
    end
    if (EFFECT_TIMER < 1) begin : g_bad_timer
        $error("pattern_scan_gen: EFFECT_TIMER must be >= 1");
    end

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    logic [TW-1:0] timer;
    logic          tick;
    logic [PW-1:0] pos, pos_nxt, pos_max;
    dir_t          dir, dir_nxt;
    logic [1:0]    mode_q, mode_nxt;
    logic          done_nxt;
    logic [3:0]    addr_cnt;
    logic          top_hit, bot_hit;
    logic [N-1:0]  col_hit, mask_top, mask_bot;
    logic [6*N-1:0] row_nxt;
`ifdef PATTERN_SCAN_MIRROR_EN
    logic [PW-1:0] mpos;
`endif

    function automatic logic bar_hit(input logic [PW-1:0] p, input logic [PW-1:0] idx);
        return (idx >= p) && (idx < p + PW'(BAR_W));
    endfunction

    assign tick    = enable_in && (timer == TW'(EFFECT_TIMER));
    assign pos_max = mode_q[0] ? POS_MAX_H : POS_MAX_V;

    always_ff @(posedge clk_in) begin
        if (!n_reset_in) begin
            timer <= '0;
        end else if (enable_in) begin
            timer <= tick ? '0 : timer + 1'b1;
        end
    end

    // Bar motion: a mode change restarts the sweep instead of stepping
    always_comb begin
        pos_nxt  = pos;
        dir_nxt  = dir;
        mode_nxt = mode_q;
        done_nxt = 1'b0;
        if (tick) begin
            if (mode_in != mode_q) begin
                mode_nxt = mode_in;
                pos_nxt  = '0;
                dir_nxt  = DIR_UP;
            end else if (mode_q[1]) begin
                if (pos == pos_max) begin
                    pos_nxt  = '0;
                    done_nxt = 1'b1;
                end else begin
                    pos_nxt = pos + 1'b1;
                end
            end else begin
                if (dir == DIR_UP) begin
                    if (pos == pos_max) begin
                        dir_nxt = DIR_DOWN;
                        pos_nxt = pos - 1'b1;
                    end else begin
                        pos_nxt = pos + 1'b1;
                    end
                end else begin
                    if (pos == '0) begin
                        dir_nxt = DIR_UP;
                        pos_nxt = PW'(1);
                    end else begin
                        pos_nxt = pos - 1'b1;
                    end
                end
                done_nxt = (pos_nxt == '0) || (pos_nxt == pos_max);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!n_reset_in) begin
            pos    <= '0;
            dir    <= DIR_UP;
            mode_q <= 2'b00;
        end else begin
            pos    <= pos_nxt;
            dir    <= dir_nxt;
            mode_q <= mode_nxt;
        end
    end

    always_comb begin
        top_hit = bar_hit(pos, PW'(addr_cnt));
        bot_hit = bar_hit(pos, PW'(addr_cnt) + HALF);
        col_hit = '0;
        for (int c = 0; c < N; c++) begin
            col_hit[c] = bar_hit(pos, PW'(c));
        end
`ifdef PATTERN_SCAN_MIRROR_EN
        mpos    = pos_max - pos;
        top_hit = top_hit | bar_hit(mpos, PW'(addr_cnt));
        bot_hit = bot_hit | bar_hit(mpos, PW'(addr_cnt) + HALF);
        for (int c = 0; c < N; c++) begin
            col_hit[c] = col_hit[c] | bar_hit(mpos, PW'(c));
        end
`endif
        mask_top = mode_q[0] ? col_hit : {N{top_hit}};
        mask_bot = mode_q[0] ? col_hit : {N{bot_hit}};
        row_nxt  = {mask_bot & {N{colour_in[2]}}, mask_bot & {N{colour_in[1]}}, mask_bot & {N{colour_in[0]}},
                    mask_top & {N{colour_in[2]}}, mask_top & {N{colour_in[1]}}, mask_top & {N{colour_in[0]}}};
    end

    // Stage p1: registered outputs, one cycle behind addr_cnt/pos
    always_ff @(posedge clk_in) begin
        if (!n_reset_in) begin
            addr_cnt        <= '0;
            row_address_out <= '0;
            row_out         <= '0;
            sweep_done_out  <= 1'b0;
        end else begin
            addr_cnt        <= addr_cnt + 1'b1;
            row_address_out <= addr_cnt;
            row_out         <= row_nxt;
            sweep_done_out  <= done_nxt;
        end
    end
endmodule

// File: tb/tb_pattern_scan_gen.sv
// Scoreboard bench for pattern_scan_gen (EFFECT_TIMER=3, BAR_W=2, 32x64 panel).
module tb_pattern_scan_gen;
    localparam int ET = 3;
    localparam int BW = 2;
    localparam int NC = 64;
    localparam int NR = 32;
    localparam int RW = 6 * NC;

    logic          clk = 1'b0;
    logic          n_reset;
    logic          en;
    logic [2:0]    colour;
    logic [1:0]    mode;
    logic [RW-1:0] row_out;
    logic [3:0]    addr_out;
    logic          done_out;

    always #5 clk = ~clk;

    pattern_scan_gen #(.EFFECT_TIMER(ET), .BAR_W(BW)) dut (
        .clk_in(clk), .n_reset_in(n_reset), .enable_in(en), .colour_in(colour), .mode_in(mode),
        .row_out(row_out), .row_address_out(addr_out), .sweep_done_out(done_out)
    );

    typedef struct packed {
        logic [RW-1:0] row;
        logic [3:0]    addr;
        logic          done;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int errors = 0;
    int checks = 0;

    int m_timer = 0, m_pos = 0, m_dir = 0, m_addr = 0;
    logic [1:0] m_mode = 2'b00;

    function automatic logic [RW-1:0] exp_row(int addr, int pos, logic [1:0] md, logic [2:0] col);
        logic [RW-1:0] r;
        int pmax, idx;
        logic lit;
        r = '0;
        pmax = (md[0] ? NC : NR) - BW;
        for (int h = 0; h < 2; h++) begin
            for (int c = 0; c < NC; c++) begin
                idx = md[0] ? c : addr + 16 * h;
                lit = (idx >= pos) && (idx < pos + BW);
`ifdef PATTERN_SCAN_MIRROR_EN
                lit = lit | ((idx >= pmax - pos) && (idx < pmax - pos + BW));
`endif
                for (int k = 0; k < 3; k++) r[h*3*NC + k*NC + c] = lit & col[k];
            end
        end
        return r;
    endfunction

    // Push the expectation for the next edge, advance the model, then wait for the edge to settle.
    task automatic clk_step();
        exp_t e;
        logic tk;
        int pmax;
        e.addr = 4'(m_addr);
        e.row  = exp_row(m_addr, m_pos, m_mode, colour);
        e.done = 1'b0;
        if (!n_reset) begin
            e = '0;
            m_timer = 0; m_pos = 0; m_dir = 0; m_mode = 2'b00; m_addr = 0;
        end else begin
            pmax = (m_mode[0] ? NC : NR) - BW;
            tk = en && (m_timer == ET);
            if (en) m_timer = tk ? 0 : m_timer + 1;
            if (tk) begin
                if (mode != m_mode) begin
                    m_mode = mode; m_pos = 0; m_dir = 0;
                end else if (m_mode[1]) begin
                    if (m_pos == pmax) begin m_pos = 0; e.done = 1'b1; end
                    else m_pos = m_pos + 1;
                end else begin
                    if (m_dir == 0) begin
                        if (m_pos == pmax) begin m_dir = 1; m_pos = m_pos - 1; end
                        else m_pos = m_pos + 1;
                    end else begin
                        if (m_pos == 0) begin m_dir = 0; m_pos = 1; end
                        else m_pos = m_pos - 1;
                    end
                    e.done = (m_pos == 0) || (m_pos == pmax);
                end
            end
            m_addr = (m_addr + 1) % 16;
        end
        sb_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic advance_to(input int p, input logic [1:0] md, input int d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (m_pos == p && m_mode == md && (d < 0 || m_dir == d)) begin
                ok = 1'b1;
                break;
            end
            clk_step();
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checks += 3;
            if (row_out !== mon_e.row) begin
                errors++;
                $display("FAIL sb_row t=%0t got %h want %h", $time, row_out, mon_e.row);
            end
            if (addr_out !== mon_e.addr) begin
                errors++;
                $display("FAIL sb_addr t=%0t got %0d want %0d", $time, addr_out, mon_e.addr);
            end
            if (done_out !== mon_e.done) begin
                errors++;
                $display("FAIL sb_done t=%0t got %0b want %0b", $time, done_out, mon_e.done);
            end
        end
    end

    task automatic test_reset();
        n_reset = 1'b0; en = 1'b1; mode = 2'b00; colour = 3'b001;
        repeat (5) clk_step();
        checks += 3;
        if (row_out !== '0) begin errors++; $display("FAIL reset_row got %h want 0", row_out); end
        if (addr_out !== 4'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", addr_out); end
        if (done_out !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done_out); end
        n_reset = 1'b1;
        for (int i = 0; i < 17; i++) begin
            clk_step();
            checks++;
            if (addr_out !== 4'(i % 16)) begin
                errors++; $display("FAIL reset_addr_seq got %0d want %0d", addr_out, i % 16);
            end
        end
    endtask

    task automatic test_vertical_bounce();
        bit ok;
        logic [RW-1:0] want;
        mode = 2'b00; colour = 3'b001; en = 1'b1;
        advance_to(5, 2'b00, 0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bounce_reach5 got timeout want pos 5"); end
        en = 1'b0;
        repeat (2) clk_step();
        for (int i = 0; i < 16; i++) begin
            clk_step();
            if (addr_out == 4'd5 || addr_out == 4'd6 || addr_out == 4'd7) begin
                want = (addr_out == 4'd7) ? '0 : {320'b0, {64{1'b1}}};
                checks++;
                if (row_out !== want) begin
                    errors++; $display("FAIL bounce_pos5 addr=%0d got %h want %h", addr_out, row_out, want);
                end
            end
        end
        en = 1'b1;
        advance_to(15, 2'b00, 0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bounce_reach15 got timeout want pos 15"); end
        en = 1'b0;
        repeat (2) clk_step();
        for (int i = 0; i < 16; i++) begin
            clk_step();
            if (addr_out == 4'd15 || addr_out == 4'd0) begin
                want = (addr_out == 4'd15) ? {320'b0, {64{1'b1}}} : {128'b0, {64{1'b1}}, 192'b0};
                checks++;
                if (row_out !== want) begin
                    errors++; $display("FAIL bounce_straddle addr=%0d got %h want %h", addr_out, row_out, want);
                end
            end
        end
        en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin clk_step(); ok = done_out; end
        checks++;
        if (!ok || m_pos != 30) begin
            errors++; $display("FAIL bounce_done_top got pos %0d seen %0b want pos 30", m_pos, ok);
        end
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin clk_step(); ok = done_out; end
        checks++;
        if (!ok || m_pos != 0) begin
            errors++; $display("FAIL bounce_done_bottom got pos %0d seen %0b want pos 0", m_pos, ok);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int pulses;
        mode = 2'b10; en = 1'b1;
        advance_to(29, 2'b10, -1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_reach29 got timeout want pos 29"); end
        pulses = 0;
        for (int i = 0; i < 40 && m_pos != 1; i++) begin
            clk_step();
            if (done_out) begin
                pulses++;
                checks++;
                if (m_pos != 0) begin errors++; $display("FAIL wrap_done_pos got %0d want 0", m_pos); end
            end
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL wrap_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_horizontal();
        bit ok;
        logic [63:0] mask;
        logic [RW-1:0] want;
        mode = 2'b01; colour = 3'b110; en = 1'b1;
        mask = 64'h0000_0000_0000_0C00;
`ifdef PATTERN_SCAN_MIRROR_EN
        mask = mask | 64'h0030_0000_0000_0000;
`endif
        want = {mask, mask, 64'h0, mask, mask, 64'h0};
        advance_to(10, 2'b01, -1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL horiz_reach10 got timeout want pos 10"); end
        en = 1'b0;
        repeat (2) clk_step();
        for (int i = 0; i < 16; i++) begin
            clk_step();
            checks++;
            if (row_out !== want) begin
                errors++; $display("FAIL horiz_pos10 addr=%0d got %h want %h", addr_out, row_out, want);
            end
        end
    endtask

    task automatic test_mode_change();
        bit ok;
        logic [3:0] prev;
        logic [63:0] mask;
        logic [RW-1:0] want;
        mode = 2'b00; colour = 3'b001; en = 1'b1;
        advance_to(17, 2'b00, 1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL modechg_reach17 got timeout want pos 17 down"); end
        mode = 2'b01;
        for (int i = 0; i < 8 && m_mode != 2'b01; i++) clk_step();
        checks++;
        if (done_out !== 1'b0 || m_mode != 2'b01) begin
            errors++; $display("FAIL modechg_done got %0b want 0", done_out);
        end
        en = 1'b0;
        mask = 64'h0000_0000_0000_0003;
`ifdef PATTERN_SCAN_MIRROR_EN
        mask = mask | 64'hC000_0000_0000_0000;
`endif
        want = {128'b0, mask, 128'b0, mask};
        prev = addr_out;
        for (int i = 0; i < 20; i++) begin
            clk_step();
            checks += 2;
            if (addr_out !== prev + 4'd1) begin
                errors++; $display("FAIL freeze_addr got %0d want %0d", addr_out, prev + 4'd1);
            end
            if (row_out !== want) begin
                errors++; $display("FAIL freeze_row got %h want %h", row_out, want);
            end
            prev = addr_out;
        end
        en = 1'b1;
    endtask

    task automatic test_mirror();
        bit ok;
        logic [RW-1:0] want;
        mode = 2'b00; colour = 3'b001; en = 1'b1;
        advance_to(3, 2'b00, 0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mirror_reach3 got timeout want pos 3"); end
        en = 1'b0;
        repeat (2) clk_step();
        for (int i = 0; i < 16; i++) begin
            clk_step();
            if (addr_out == 4'd3 || addr_out == 4'd4 || addr_out == 4'd11 || addr_out == 4'd12) begin
                if (addr_out < 4'd8) want = {320'b0, {64{1'b1}}};
                else begin
`ifdef PATTERN_SCAN_MIRROR_EN
                    want = {128'b0, {64{1'b1}}, 192'b0};
`else
                    want = '0;
`endif
                end
                checks++;
                if (row_out !== want) begin
                    errors++; $display("FAIL mirror_pos3 addr=%0d got %h want %h", addr_out, row_out, want);
                end
            end
        end
        en = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            colour  = 3'($urandom_range(0, 7));
            en      = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
            n_reset = ($urandom_range(0, 149) != 0);
            clk_step();
        end
        n_reset = 1'b1;
        clk_step();
    endtask

    initial begin
        n_reset = 1'b0; en = 1'b0; mode = 2'b00; colour = 3'b000;
        #1;
        test_reset();
        test_vertical_bounce();
        test_wrap();
        test_horizontal();
        test_mode_change();
        test_mirror();
        test_random();
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL sb_drain got %0d entries want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
